preg_free_list_mw: RTL and testbench

PREG_FREE_LIST_MW -- requirements
Module: preg_free_list_mw

---
 rtl/preg_free_list_mw_pkg.sv | 20 ++
 rtl/preg_free_list_mw.sv | 137 +++++++++++++
 tb/tb_preg_free_list_mw.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/preg_free_list_mw_pkg.sv
// Shared widths and types for the multi-way physical register free list.
// The free-list module sizes its index, pointer and checkpoint-id fields
// from these constants only.
package preg_free_list_mw_pkg;

    localparam int unsigned PRF_NUM_DEF  = 64;
    localparam int unsigned ARF_NUM_DEF  = 32;
    localparam int unsigned CKPT_NUM_DEF = 4;
    localparam int unsigned FL_NUM_DEF   = PRF_NUM_DEF - ARF_NUM_DEF;

    localparam int unsigned PRF_IDX_W = $clog2(PRF_NUM_DEF);
    localparam int unsigned FL_IDX_W  = $clog2(FL_NUM_DEF);
    localparam int unsigned FL_PTR_W  = FL_IDX_W + 1;
    localparam int unsigned CKPT_ID_W = $clog2(CKPT_NUM_DEF);

    typedef logic [PRF_IDX_W-1:0] preg_t;
    typedef logic [FL_IDX_W-1:0]  fl_idx_t;
    typedef logic [FL_PTR_W-1:0]  fl_ptr_t;

endpackage

// File: rtl/preg_free_list_mw.sv
// Physical register free list with multi-way allocate/free and branch
// checkpoints of the head pointer.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   disp_req_cnt_i      pregs requested this cycle (all-or-nothing grant)
//   disp_gnt_o          request granted
//   free_preg_o         entries at head..head+DISP_W-1, always driven
//   retire_vld_i        per-lane free valid
//   retire_preg_i       pregs being returned, compacted in lane order
//   ckpt_save_en_i      save head+ckpt_ofs_i into slot ckpt_id_i (if granted)
//   ckpt_id_i, ckpt_ofs_i
//   br_recover_en_i     restore head from slot br_recover_id_i
//   br_recover_id_i
//   free_cnt_o          number of free entries
//   empty_o             free_cnt_o == 0
module preg_free_list_mw
    import preg_free_list_mw_pkg::*;
#(
    parameter int unsigned PRF_NUM  = PRF_NUM_DEF,
    parameter int unsigned ARF_NUM  = ARF_NUM_DEF,
    parameter int unsigned DISP_W   = 2,
    parameter int unsigned RET_W    = 2,
    parameter int unsigned CKPT_NUM = CKPT_NUM_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [$clog2(DISP_W+1)-1:0]            disp_req_cnt_i,
    output logic                                   disp_gnt_o,
    output preg_t [DISP_W-1:0]                     free_preg_o,
    input  logic [RET_W-1:0]                       retire_vld_i,
    input  preg_t [RET_W-1:0]                      retire_preg_i,
    input  logic                                   ckpt_save_en_i,
    input  logic [CKPT_ID_W-1:0]                   ckpt_id_i,
    input  logic [$clog2(DISP_W+1)-1:0]            ckpt_ofs_i,
    input  logic                                   br_recover_en_i,
    input  logic [CKPT_ID_W-1:0]                   br_recover_id_i,
    output logic [$clog2(PRF_NUM-ARF_NUM+1)-1:0]   free_cnt_o,
    output logic                                   empty_o
);

    localparam int unsigned FL_NUM = PRF_NUM - ARF_NUM;
    localparam int unsigned CNT_W  = $clog2(FL_NUM + 1);

    preg_t       fl_q   [FL_NUM];
    fl_ptr_t     head_q;
    fl_ptr_t     tail_q;
    fl_ptr_t     head_nxt;
    fl_ptr_t     tail_nxt;
    fl_ptr_t     ckpt_q [CKPT_NUM];
    fl_idx_t     ret_slot [RET_W];
    int unsigned count;
    int unsigned ret_pop;
    logic        ret_ok;

    // Pointer = {wrap, index}; index stays below FL_NUM so a non power-of-two
    // list still visits every entry before wrapping.
    function automatic fl_ptr_t ptr_add(fl_ptr_t p, int unsigned n);
        int unsigned idx;
        logic        wrap;
        idx  = 32'(p[FL_IDX_W-1:0]) + n;
        wrap = p[FL_PTR_W-1];
        if (idx >= FL_NUM) begin
            idx  = idx - FL_NUM;
            wrap = ~wrap;
        end
        return {wrap, fl_idx_t'(idx)};
    endfunction

    function automatic int unsigned ptr_diff(fl_ptr_t t, fl_ptr_t h);
        if (t[FL_PTR_W-1] == h[FL_PTR_W-1])
            return 32'(t[FL_IDX_W-1:0]) - 32'(h[FL_IDX_W-1:0]);
        return FL_NUM + 32'(t[FL_IDX_W-1:0]) - 32'(h[FL_IDX_W-1:0]);
    endfunction

    function automatic fl_idx_t idx_of(fl_ptr_t p);
        return p[FL_IDX_W-1:0];
    endfunction

    // Valid lanes strictly below 'lane'; lane = RET_W gives the popcount.
    // This is the compaction offset of each retire lane from the tail.
    function automatic int unsigned lanes_below(logic [RET_W-1:0] vld, int unsigned lane);
        int unsigned n;
        n = 0;
        for (int unsigned l = 0; l < RET_W; l++)
            if (l < lane && vld[l]) n = n + 1;
        return n;
    endfunction

    always_comb begin
        // Grant uses the pre-retire count: frees are never bypassed to dispatch.
        count      = ptr_diff(tail_q, head_q);
        disp_gnt_o = (32'(disp_req_cnt_i) <= count) && !br_recover_en_i;
        ret_pop    = lanes_below(retire_vld_i, RET_W);
        tail_nxt   = ptr_add(tail_q, ret_pop);

        head_nxt = head_q;
        if (br_recover_en_i)
            head_nxt = ckpt_q[br_recover_id_i];
        else if (disp_gnt_o)
            head_nxt = ptr_add(head_q, 32'(disp_req_cnt_i));

        for (int unsigned k = 0; k < DISP_W; k++)
            free_preg_o[k] = fl_q[idx_of(ptr_add(head_q, k))];

        for (int unsigned l = 0; l < RET_W; l++)
            ret_slot[l] = idx_of(ptr_add(tail_q, lanes_below(retire_vld_i, l)));

        free_cnt_o = CNT_W'(count);
        empty_o    = (count == 0);
        ret_ok     = (ptr_diff(tail_q, head_nxt) + ret_pop) <= FL_NUM;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FL_NUM; i++)
                fl_q[i] <= preg_t'(ARF_NUM + i);
            head_q <= '0;
            tail_q <= {1'b1, fl_idx_t'(0)};
            for (int unsigned c = 0; c < CKPT_NUM; c++)
                ckpt_q[c] <= '0;
        end else begin
            head_q <= head_nxt;
            tail_q <= tail_nxt;
            for (int unsigned l = 0; l < RET_W; l++)
                if (retire_vld_i[l]) fl_q[ret_slot[l]] <= retire_preg_i[l];
            // disp_gnt_o is already low during recovery, so no save then.
            if (ckpt_save_en_i && disp_gnt_o)
                ckpt_q[ckpt_id_i] <= ptr_add(head_q, 32'(ckpt_ofs_i));
        end
    end

    retire_overflow: assert property (@(posedge clk) disable iff (!rst) ret_ok);
    ckpt_ofs_legal:  assert property (@(posedge clk) disable iff (!rst)
                                      ckpt_save_en_i |-> ckpt_ofs_i <= disp_req_cnt_i);

endmodule

// File: tb/tb_preg_free_list_mw.sv
// Self-checking bench for preg_free_list_mw. The reference model is an
// append-only log of every preg ever placed in the list, with absolute
// head/tail counters (no wrap): the list contents are log[H..T-1].
module tb_preg_free_list_mw;

    localparam int FL  = 32;
    localparam int ARF = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      disp_req_cnt;
    logic            disp_gnt;
    logic [1:0][5:0] free_preg;
    logic [1:0]      retire_vld;
    logic [1:0][5:0] retire_preg;
    logic            ckpt_save_en;
    logic [1:0]      ckpt_id;
    logic [1:0]      ckpt_ofs;
    logic            br_recover_en;
    logic [1:0]      br_recover_id;
    logic [5:0]      free_cnt;
    logic            empty;

    int vectors = 0;
    int miscompares = 0;

    int log_q[$];
    int H, T;
    int ck[4];
    bit owned[64];
    int busy[$];

    always #5 clk = ~clk;

    preg_free_list_mw #(
        .PRF_NUM(64), .ARF_NUM(32), .DISP_W(2), .RET_W(2), .CKPT_NUM(4)
    ) dut (
        .clk(clk), .rst(rst),
        .disp_req_cnt_i(disp_req_cnt), .disp_gnt_o(disp_gnt),
        .free_preg_o(free_preg),
        .retire_vld_i(retire_vld), .retire_preg_i(retire_preg),
        .ckpt_save_en_i(ckpt_save_en), .ckpt_id_i(ckpt_id), .ckpt_ofs_i(ckpt_ofs),
        .br_recover_en_i(br_recover_en), .br_recover_id_i(br_recover_id),
        .free_cnt_o(free_cnt), .empty_o(empty)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        log_q.delete();
        for (int i = 0; i < FL; i++) log_q.push_back(ARF + i);
        H = 0;
        T = FL;
        for (int c = 0; c < 4; c++) ck[c] = 0;
        for (int p = 0; p < 64; p++) owned[p] = 1'b0;
        busy.delete();
    endtask

    task automatic release_preg(int p);
        int idx[$];
        owned[p] = 1'b0;
        idx = busy.find_first_index(x) with (x == p);
        if (idx.size() != 0) busy.delete(idx[0]);
    endtask

    task automatic set_in(int req, bit [1:0] vld, int p0, int p1,
                          bit sv, int sid, int ofs, bit rec, int rid);
        disp_req_cnt   = 2'(req);
        retire_vld     = vld;
        retire_preg[0] = 6'(p0);
        retire_preg[1] = 6'(p1);
        ckpt_save_en   = sv;
        ckpt_id        = 2'(sid);
        ckpt_ofs       = 2'(ofs);
        br_recover_en  = rec;
        br_recover_id  = 2'(rid);
    endtask

    task automatic idle();
        set_in(0, 2'b00, 0, 0, 1'b0, 0, 0, 1'b0, 0);
    endtask

    // Entered at posedge+1 with inputs applied; checks the combinational
    // outputs late in the cycle, then clocks and advances the model.
    task automatic step(string tag);
        int cnt;
        bit eg;
        int p;
        cnt = T - H;
        eg  = (int'(disp_req_cnt) <= cnt) && !br_recover_en;
        #3;
        check($sformatf("%s.gnt", tag), 32'(disp_gnt), 32'(eg));
        check($sformatf("%s.cnt", tag), 32'(free_cnt), cnt);
        check($sformatf("%s.empty", tag), 32'(empty), 32'(cnt == 0));
        for (int k = 0; k < 2; k++)
            if (H + k < T)
                check($sformatf("%s.preg%0d", tag, k), 32'(free_preg[k]), log_q[H + k]);
        @(posedge clk);
        if (br_recover_en) begin
            for (int a = ck[br_recover_id]; a < H; a++) release_preg(log_q[a]);
            H = ck[br_recover_id];
        end else if (eg) begin
            if (ckpt_save_en) ck[ckpt_id] = H + int'(ckpt_ofs);
            for (int j = 0; j < int'(disp_req_cnt); j++) begin
                p = log_q[H + j];
                check($sformatf("%s.dup%0d", tag, p), 32'(owned[p]), 0);
                owned[p] = 1'b1;
                busy.push_back(p);
            end
            H = H + int'(disp_req_cnt);
        end
        for (int l = 0; l < 2; l++)
            if (retire_vld[l]) begin
                log_q.push_back(int'(retire_preg[l]));
                release_preg(int'(retire_preg[l]));
                T++;
            end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int req, n, cnt, ofs, bi;
        bit [1:0] vld;
        int pr[2];

        idle();
        #1;
        do_reset();

        // Reset values
        check("rst.cnt", 32'(free_cnt), 32);
        check("rst.empty", 32'(empty), 0);
        check("rst.p0", 32'(free_preg[0]), 32);
        check("rst.p1", 32'(free_preg[1]), 33);

        // First allocation and head advance
        set_in(2, 2'b00, 0, 0, 1'b0, 0, 0, 1'b0, 0);
        #1;
        check("a028.gnt", 32'(disp_gnt), 1);
        check("a028.p0", 32'(free_preg[0]), 32);
        check("a028.p1", 32'(free_preg[1]), 33);
        step("a028");
        check("b028.p0", 32'(free_preg[0]), 34);
        check("b028.p1", 32'(free_preg[1]), 35);
        check("b028.cnt", 32'(free_cnt), 30);

        // Drain to empty, refused request, refill with two frees
        for (int i = 0; i < 15; i++) step("drain");
        check("r029.empty", 32'(empty), 1);
        set_in(1, 2'b00, 0, 0, 1'b0, 0, 0, 1'b0, 0);
        #1;
        check("r029.gnt", 32'(disp_gnt), 0);
        step("r029req");
        set_in(0, 2'b11, 40, 41, 1'b0, 0, 0, 1'b0, 0);
        step("r029ret");
        idle();
        check("r029.cnt", 32'(free_cnt), 2);
        check("r029.p0", 32'(free_preg[0]), 40);
        check("r029.p1", 32'(free_preg[1]), 41);
        step("r029idle");

        // Checkpoint save mid-group, further allocation, recovery
        do_reset();
        set_in(2, 2'b00, 0, 0, 1'b1, 1, 1, 1'b0, 0);
        step("r030s");
        set_in(2, 2'b00, 0, 0, 1'b0, 0, 0, 1'b0, 0);
        step("r030a");
        step("r030b");
        check("r030.pre", 32'(free_cnt), 26);
        set_in(2, 2'b00, 0, 0, 1'b0, 0, 0, 1'b1, 1);
        step("r030rec");
        idle();
        check("r030.p0", 32'(free_preg[0]), 33);
        check("r030.cnt", 32'(free_cnt), 31);

        // Recovery, retire and request in the same cycle
        set_in(2, 2'b00, 0, 0, 1'b1, 2, 2, 1'b0, 0);
        step("r031s");
        set_in(2, 2'b00, 0, 0, 1'b0, 0, 0, 1'b0, 0);
        step("r031a");
        set_in(2, 2'b11, 33, 34, 1'b0, 0, 0, 1'b1, 2);
        #1;
        check("r031.gnt", 32'(disp_gnt), 0);
        step("r031");
        idle();
        check("r031.cnt", 32'(free_cnt), 31);
        check("r031.p0", 32'(free_preg[0]), 35);
        check("r031.p1", 32'(free_preg[1]), 36);

        // Asynchronous reset in the middle of an allocation cycle
        set_in(2, 2'b00, 0, 0, 1'b0, 0, 0, 1'b0, 0);
        step("r033a");
        #2;
        rst = 1'b0;
        #1;
        check("r033.cnt", 32'(free_cnt), 32);
        check("r033.empty", 32'(empty), 0);
        check("r033.p0", 32'(free_preg[0]), 32);
        check("r033.p1", 32'(free_preg[1]), 33);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        idle();
        step("r033post");

        // Random allocate/free traffic across several pointer wraps
        do_reset();
        for (int it = 0; it < 200; it++) begin
            req = $urandom_range(0, 2);
            cnt = T - H;
            n = $urandom_range(0, 2);
            if (n > busy.size()) n = busy.size();
            if (n > FL - cnt) n = FL - cnt;
            vld = 2'b00;
            pr[0] = 0;
            pr[1] = 0;
            if (n == 2) vld = 2'b11;
            else if (n == 1) vld = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
            for (int l = 0; l < 2; l++)
                if (vld[l]) begin
                    bi = $urandom_range(0, busy.size() - 1);
                    pr[l] = busy[bi];
                    busy.delete(bi);
                end
            ofs = $urandom_range(0, req);
            set_in(req, vld, pr[0], pr[1], ($urandom_range(0, 3) == 0),
                   $urandom_range(0, 3), ofs, 1'b0, 0);
            step("rnd");
        end
        idle();
        step("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
